// File: rtl/tetris_move_scheduler.sv
// Move scheduler for the tetris playfield: latches button pulses, generates the
// gravity tick from the level, and issues one command at a time to the board.
//
// Command handshake: cmd_valid rises with cmd_op stable and both hold until the
// board returns a one-cycle cmd_ack (qualified by cmd_ok). cmd_valid drops on
// the edge that samples cmd_ack, and stays low for at least one cycle before the
// next command. cmd_ack is ignored whenever cmd_valid is low.
module tetris_move_scheduler #(
  parameter int          CNT_W     = 27,
  parameter int unsigned GRAV_BASE = 100000000,
  parameter int unsigned GRAV_STEP = 6000000,
  parameter int unsigned GRAV_MIN  = 5000000
) (
  input  logic       clk,
  input  logic       sw_rst,
  input  logic       btn_drop,
  input  logic       btn_rotate,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       sw_pause,
  input  logic [3:0] level,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  input  logic       cmd_ack,
  input  logic       cmd_ok,
  output logic       game_over,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {S_SPAWN_REQ, S_IDLE, S_ISSUE, S_HALT} state_t;
  typedef enum logic [1:0] {SEQ_NONE, SEQ_HARD, SEQ_LOCK, SEQ_SPAWN} seq_t;

  localparam logic [2:0] OP_NONE   = 3'd0;
  localparam logic [2:0] OP_LEFT   = 3'd1;
  localparam logic [2:0] OP_RIGHT  = 3'd2;
  localparam logic [2:0] OP_ROTATE = 3'd3;
  localparam logic [2:0] OP_DOWN   = 3'd4;
  localparam logic [2:0] OP_LOCK   = 3'd5;
  localparam logic [2:0] OP_SPAWN  = 3'd6;

  // Pending flag index; lower index wins arbitration.
  localparam int P_DROP = 0;
  localparam int P_ROT  = 1;
  localparam int P_LEFT = 2;
  localparam int P_RGT  = 3;
  localparam int P_DOWN = 4;
  localparam int P_GRAV = 5;

  state_t           r_state, w_state_nx;
  seq_t             r_seq, w_seq_nx;
  logic             r_cmd_valid, w_cmd_valid_nx;
  logic [2:0]       r_cmd_op, w_cmd_op_nx;
  logic             r_game_over, w_game_over_nx;
  logic [5:0]       r_pend;
  logic             r_pause_d;
  logic [CNT_W-1:0] r_cnt;

  logic [5:0]       w_clr;
  logic [2:0]       w_issue_op;
  logic             w_down_ok;
  logic [4:0]       w_btn;
  logic [31:0]      w_reduce;
  logic [31:0]      w_period32;
  logic [CNT_W-1:0] w_period;
  logic             w_cnt_en;
  logic             w_tick;

  assign w_btn = {btn_down, btn_right, btn_left, btn_rotate, btn_drop};

  // Gravity period from level, clamped at GRAV_MIN without underflow; tick on compare.
  always_comb begin
    w_reduce = 32'(level) * GRAV_STEP;
    if (w_reduce > GRAV_BASE - GRAV_MIN) begin
      w_period32 = GRAV_MIN;
    end else begin
      w_period32 = GRAV_BASE - w_reduce;
    end
    w_period = CNT_W'(w_period32);
    w_cnt_en = !sw_pause && !r_game_over && (r_seq == SEQ_NONE);
    w_tick   = w_cnt_en && (r_cnt >= w_period - CNT_W'(1));
  end

  // Next-state: op selection in IDLE, ack bookkeeping in ISSUE.
  always_comb begin
    w_state_nx     = r_state;
    w_seq_nx       = r_seq;
    w_cmd_valid_nx = r_cmd_valid;
    w_cmd_op_nx    = r_cmd_op;
    w_game_over_nx = r_game_over;
    w_clr          = '0;
    w_issue_op     = OP_NONE;
    w_down_ok      = 1'b0;
    case (r_state)
      S_SPAWN_REQ: begin
        w_cmd_op_nx    = OP_SPAWN;
        w_cmd_valid_nx = 1'b1;
        w_state_nx     = S_ISSUE;
      end
      S_IDLE: begin
        // Sequence steps ignore pause; fresh requests wait for it to drop.
        if (r_seq == SEQ_HARD) begin
          w_issue_op = OP_DOWN;
        end else if (r_seq == SEQ_LOCK) begin
          w_issue_op = OP_LOCK;
        end else if (r_seq == SEQ_SPAWN) begin
          w_issue_op = OP_SPAWN;
        end else if (!sw_pause) begin
          if (r_pend[P_DROP]) begin
            w_issue_op    = OP_DOWN;
            w_seq_nx      = SEQ_HARD;
            w_clr[P_DROP] = 1'b1;
          end else if (r_pend[P_ROT]) begin
            w_issue_op   = OP_ROTATE;
            w_clr[P_ROT] = 1'b1;
          end else if (r_pend[P_LEFT]) begin
            w_issue_op    = OP_LEFT;
            w_clr[P_LEFT] = 1'b1;
          end else if (r_pend[P_RGT]) begin
            w_issue_op   = OP_RIGHT;
            w_clr[P_RGT] = 1'b1;
          end else if (r_pend[P_DOWN]) begin
            w_issue_op    = OP_DOWN;
            w_clr[P_DOWN] = 1'b1;
          end else if (r_pend[P_GRAV]) begin
            w_issue_op    = OP_DOWN;
            w_clr[P_GRAV] = 1'b1;
          end
        end
        if (w_issue_op != OP_NONE) begin
          w_cmd_op_nx    = w_issue_op;
          w_cmd_valid_nx = 1'b1;
          w_state_nx     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ack) begin
          w_cmd_valid_nx = 1'b0;
          w_state_nx     = S_IDLE;
          case (r_cmd_op)
            OP_DOWN: begin
              if (cmd_ok) w_down_ok = 1'b1;
              else        w_seq_nx  = SEQ_LOCK;
            end
            OP_LOCK: w_seq_nx = SEQ_SPAWN;
            OP_SPAWN: begin
              // Any spawn result ends the sequence; a rejected spawn ends the game.
              w_seq_nx = SEQ_NONE;
              if (!cmd_ok) begin
                w_game_over_nx = 1'b1;
                w_state_nx     = S_HALT;
              end
            end
            default: ;
          endcase
        end
      end
      S_HALT: begin
        w_cmd_valid_nx = 1'b0;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State, sequence and command registers.
  always_ff @(posedge clk) begin
    if (!sw_rst) begin
      r_state     <= S_SPAWN_REQ;
      r_seq       <= SEQ_NONE;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= OP_NONE;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_seq       <= w_seq_nx;
      r_cmd_valid <= w_cmd_valid_nx;
      r_cmd_op    <= w_cmd_op_nx;
      r_game_over <= w_game_over_nx;
    end
  end

  // Gravity counter: restarts on a successful DOWN or on its own tick.
  always_ff @(posedge clk) begin
    if (!sw_rst) begin
      r_cnt <= '0;
    end else if (w_down_ok || w_tick) begin
      r_cnt <= '0;
    end else if (w_cnt_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Pending flags: set by pulse, cleared on issue, flushed on pause rise, frozen in HALT.
  always_ff @(posedge clk) begin
    if (!sw_rst) begin
      r_pend    <= '0;
      r_pause_d <= 1'b0;
    end else begin
      r_pause_d <= sw_pause;
      if (r_state != S_HALT) begin
        if (sw_pause && !r_pause_d) begin
          r_pend[4:0] <= '0;
        end else if (!sw_pause) begin
          r_pend[4:0] <= (r_pend[4:0] & ~w_clr[4:0]) | w_btn;
        end
        if (w_tick) begin
          r_pend[P_GRAV] <= 1'b1;
        end else if (w_clr[P_GRAV]) begin
          r_pend[P_GRAV] <= 1'b0;
        end
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_op    = r_cmd_op;
  assign game_over = r_game_over;
  assign dbg_state = r_state;
  // The pending spawn only counts as busy once reset is released.
  assign busy      = (r_state == S_ISSUE) | (r_seq != SEQ_NONE) |
                     ((r_state == S_SPAWN_REQ) & sw_rst);

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Bench for tetris_move_scheduler: directed scenarios, an auto-acking board,
// a cycle model of the scheduler rules and a rising-edge command log.
module tb_tetris_move_scheduler;

  localparam int G_BASE = 20;
  localparam int G_STEP = 4;
  localparam int G_MIN  = 4;

  logic       clk = 1'b0;
  logic       sw_rst = 1'b0;
  logic       btn_drop = 1'b0, btn_rotate = 1'b0, btn_left = 1'b0;
  logic       btn_right = 1'b0, btn_down = 1'b0;
  logic       sw_pause = 1'b0;
  logic [3:0] level = 4'd0;
  logic       cmd_ack = 1'b0, cmd_ok = 1'b0;
  logic       cmd_valid, game_over, busy;
  logic [2:0] cmd_op;
  logic [1:0] dbg_state;

  tetris_move_scheduler #(
    .CNT_W(8), .GRAV_BASE(G_BASE), .GRAV_STEP(G_STEP), .GRAV_MIN(G_MIN)
  ) dut (
    .clk(clk), .sw_rst(sw_rst), .btn_drop(btn_drop), .btn_rotate(btn_rotate),
    .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
    .sw_pause(sw_pause), .level(level), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ack(cmd_ack), .cmd_ok(cmd_ok), .game_over(game_over), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int base  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- board responder: ack 2 cycles after cmd_valid rises ----------------
  bit ok_q[$];
  int vcnt = 0;
  always @(negedge clk) begin
    if (sw_rst && cmd_valid === 1'b1) vcnt++;
    else vcnt = 0;
    if (vcnt == 2) begin
      cmd_ack = 1'b1;
      cmd_ok  = (ok_q.size() != 0) ? ok_q.pop_front() : 1'b1;
    end else begin
      cmd_ack = 1'b0;
      cmd_ok  = 1'b0;
    end
  end

  // ---------------- command log (rising edges of cmd_valid) ----------------
  int rise_op_q[$];
  int rise_cyc_q[$];
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    if (cmd_valid === 1'b1 && !prev_v) begin
      rise_op_q.push_back(int'(cmd_op));
      rise_cyc_q.push_back(cyc);
    end
    prev_v = (cmd_valid === 1'b1);
  end

  // ---------------- behavioural model ----------------
  // Sources in priority order: drop, rotate, left, right, down, gravity.
  int op_of [6] = '{4, 3, 1, 2, 4, 4};
  bit m_pend [6];
  bit model_live = 1'b0;
  bit m_valid, m_fresh, m_dead, m_prev_pause;
  int m_op, m_seq, m_cnt;  // m_seq: op the running sequence issues next, 0 = none

  always @(posedge clk) begin : model_step
    int lv, per, src;
    bit en, tick, dead0, down_ok;
    bit [4:0] btn;
    if (!sw_rst) begin
      model_live = 1'b1;
      m_valid = 0; m_op = 0; m_fresh = 1; m_dead = 0; m_seq = 0; m_cnt = 0;
      m_prev_pause = 0;
      for (int i = 0; i < 6; i++) m_pend[i] = 0;
    end else begin
      lv    = int'(level);
      per   = (lv * G_STEP > G_BASE - G_MIN) ? G_MIN : G_BASE - lv * G_STEP;
      dead0 = m_dead;
      en    = !sw_pause && !m_dead && (m_seq == 0);
      tick  = en && (m_cnt >= per - 1);
      src   = -1;
      down_ok = 0;
      btn   = {btn_down, btn_right, btn_left, btn_rotate, btn_drop};
      if (!m_dead) begin
        if (m_valid) begin
          if (cmd_ack) begin
            m_valid = 0;
            if (m_op == 4) begin
              if (cmd_ok) down_ok = 1;
              else m_seq = 5;
            end else if (m_op == 5) begin
              m_seq = 6;
            end else if (m_op == 6) begin
              m_seq = 0;
              if (!cmd_ok) m_dead = 1;
            end
          end
        end else if (m_fresh) begin
          m_fresh = 0; m_valid = 1; m_op = 6;
        end else if (m_seq != 0) begin
          m_valid = 1; m_op = m_seq;
        end else if (!sw_pause) begin
          for (int i = 5; i >= 0; i--) if (m_pend[i]) src = i;
          if (src >= 0) begin
            m_valid = 1; m_op = op_of[src];
            if (src == 0) m_seq = 4;
          end
        end
      end
      if (down_ok || tick) m_cnt = 0;
      else if (en) m_cnt++;
      if (!dead0) begin
        for (int i = 0; i < 5; i++) begin
          if (sw_pause && !m_prev_pause) m_pend[i] = 0;
          else if (!sw_pause) m_pend[i] = (m_pend[i] && src != i) || btn[i];
        end
        if (tick) m_pend[5] = 1;
        else if (src == 5) m_pend[5] = 0;
      end
      m_prev_pause = sw_pause;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (model_live) begin
      check("cmd_valid", cmd_valid, m_valid);
      check("game_over", game_over, m_dead);
      check("busy", busy, (m_valid || m_seq != 0 || (m_fresh && sw_rst)) ? 1 : 0);
      if (m_valid) check("cmd_op", cmd_op, m_op);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_to(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic do_reset(input int edges, input logic [3:0] lv);
    @(negedge clk);
    sw_rst = 1'b0; sw_pause = 1'b0; level = lv;
    {btn_drop, btn_rotate, btn_left, btn_right, btn_down} = '0;
    for (int i = 0; i < edges; i++) @(negedge clk);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_op", cmd_op, 0);
    check("rst_game_over", game_over, 0);
    check("rst_busy", busy, 0);
    ok_q.delete(); rise_op_q.delete(); rise_cyc_q.delete();
    sw_rst = 1'b1;
    base = cyc;
  endtask

  // Buttons are set for the edge after cycle c only.
  task automatic pulse_at(input int c, input bit d, input bit r, input bit l,
                          input bit rt, input bit dn);
    tick_to(c);
    {btn_drop, btn_rotate, btn_left, btn_right, btn_down} = {d, r, l, rt, dn};
    @(negedge clk);
    {btn_drop, btn_rotate, btn_left, btn_right, btn_down} = '0;
  endtask

  // ---------------- scoreboard: expected command order and issue cycle ----------------
  logic [2:0] exp_q[$];
  int         exp_c_q[$];

  task automatic expect_cmds(input string name, input int budget);
    int n;
    logic [2:0] e_op;
    int e_c;
    while (exp_q.size() != 0) begin
      e_op = exp_q.pop_front();
      e_c  = exp_c_q.pop_front();
      n = 0;
      while (rise_op_q.size() == 0 && n < budget) begin
        @(negedge clk);
        n++;
      end
      if (rise_op_q.size() == 0) begin
        total++; bad++;
        $display("FAIL %s: no command within %0d cycles, expected op %0d", name, budget, e_op);
      end else begin
        check({name, "_op"}, rise_op_q.pop_front(), e_op);
        check({name, "_cyc"}, rise_cyc_q.pop_front() - base, e_c);
      end
    end
  endtask

  task automatic want(input logic [2:0] op, input int c);
    exp_q.push_back(op);
    exp_c_q.push_back(c);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    // 1: SPAWN first; gravity counter runs from release, period 20 -> tick at edge 20.
    do_reset(3, 4'd0);
    want(3'd6, 1); want(3'd4, 21);
    expect_cmds("s1", 40);

    // 2: rotate, left, down on one cycle -> 3,1,4, three cycles apart.
    do_reset(2, 4'd0);
    want(3'd6, 1); expect_cmds("s2_spawn", 10);
    pulse_at(base + 3, 0, 1, 1, 0, 1);
    want(3'd3, 5); want(3'd1, 8); want(3'd4, 11);
    expect_cmds("s2", 20);

    // 3: hard drop, three DOWN ok then not ok; left served after SPAWN.
    do_reset(2, 4'd0);
    want(3'd6, 1); expect_cmds("s3_spawn", 10);
    pulse_at(base + 3, 1, 0, 0, 0, 0);
    ok_q = '{1'b1, 1'b1, 1'b1, 1'b0};
    pulse_at(base + 5, 0, 0, 1, 0, 0);
    want(3'd4, 5); want(3'd4, 8); want(3'd4, 11); want(3'd4, 14);
    want(3'd5, 17); want(3'd6, 20); want(3'd1, 23);
    expect_cmds("s3", 20);

    // 4: level 5 -> period 4; level 1 -> 16; back to 5 mid-count fires at once.
    do_reset(2, 4'd5);
    want(3'd6, 1); want(3'd4, 5); want(3'd4, 12);
    expect_cmds("s4_fast", 20);
    level = 4'd1;
    want(3'd4, 31);
    expect_cmds("s4_slow", 30);
    tick_to(base + 44);
    level = 4'd5;
    want(3'd4, 46);
    expect_cmds("s4_cut", 10);

    // 5: pause with right pending and gravity near; rotate during pause dropped.
    do_reset(2, 4'd0);
    want(3'd6, 1); expect_cmds("s5_spawn", 10);
    pulse_at(base + 15, 0, 0, 0, 1, 0);
    sw_pause = 1'b1;
    pulse_at(base + 18, 0, 1, 0, 0, 0);
    tick_to(base + 25);
    sw_pause = 1'b0;
    want(3'd4, 30); want(3'd4, 53);
    expect_cmds("s5", 30);

    // 6: rejected SPAWN -> game over, no commands; one-edge reset recovers.
    do_reset(2, 4'd0);
    ok_q.push_back(1'b0);
    want(3'd6, 1); expect_cmds("s6_spawn", 10);
    tick_to(base + 4);
    check("s6_game_over_set", game_over, 1);
    pulse_at(base + 6, 1, 1, 1, 1, 1);
    tick_to(base + 40);
    check("s6_halt_no_cmd", rise_op_q.size(), 0);
    check("s6_halt_valid", cmd_valid, 0);
    do_reset(1, 4'd0);
    check("s6_game_over_clr", game_over, 0);
    want(3'd6, 1);
    expect_cmds("s6_respawn", 10);
    tick_to(base + 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
